// File: rtl/sequence_checker.sv
// sequence_checker: debounces the KEY buttons and checks presses in order
// against a latched tile sequence. Define SCORE_EN to add an 8-bit pass score.
module sequence_checker #(
  parameter int MAX_TILES       = 9,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int TIMEOUT_TICKS   = 5
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   start,
  input  logic [2*MAX_TILES-1:0] seq,
  input  logic [5:0]             seq_len,
  input  logic                   tick,
  input  logic [3:0]             key_n,
  output logic                   busy,
  output logic                   press_valid,
  output logic [1:0]             tile_pressed,
  output logic [5:0]             input_idx,
  output logic                   round_pass,
  output logic                   round_fail,
  output logic                   fail_timeout
`ifdef SCORE_EN
  ,
  output logic [7:0]             score
`endif
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [DW-1:0] DLIM  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_TICKS - 1);
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_TICKS);
  localparam logic [5:0]    LMAX  = 6'(MAX_TILES);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_PRESS,
    WAIT_RELEASE,
    PASS,
    FAIL
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]             sync1;
  logic [3:0]             sync2;
  logic [3:0]             deb;
  logic [3:0]             deb_d;
  logic [2*MAX_TILES-1:0] seq_r;
  logic [5:0]             len_r;
  logic [5:0]             len_clamp;
  logic [TW-1:0]          tcnt;
  logic                   press;
  logic                   one_down;
  logic [1:0]             key_tile;
  logic [1:0]             exp_tile;
  logic                   tcnt_last;
  logic                   idx_last;
  logic                   all_up;
  logic                   do_start;
  logic                   do_load;
  logic                   do_hit;
  logic                   do_tick;
  logic                   do_timeout;
  logic                   do_advance;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~key_n;
      sync2 <= sync1;
    end
  end

  // a level is accepted once it has differed from deb for DEBOUNCE_CYCLES
  for (genvar i = 0; i < 4; i++) begin : g_deb
    logic [DW-1:0] cnt;
    logic          lvl;
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        cnt <= '0;
        lvl <= 1'b0;
      end else if (sync2[i] == lvl) begin
        cnt <= '0;
      end else if (cnt == DLIM) begin
        cnt <= '0;
        lvl <= sync2[i];
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
    assign deb[i] = lvl;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      deb_d <= '0;
    end else begin
      deb_d <= deb;
    end
  end

  assign press     = |(deb & ~deb_d);
  assign one_down  = $onehot(deb);
  assign all_up    = (deb == 4'b0000);
  assign len_clamp = (seq_len > LMAX) ? LMAX : seq_len;
  assign tcnt_last = (tcnt >= TLAST);
  assign idx_last  = ((input_idx + 6'd1) == len_r);

  always_comb begin
    key_tile = 2'd0;
    unique case (deb)
      4'b0001: key_tile = 2'd0;
      4'b0010: key_tile = 2'd1;
      4'b0100: key_tile = 2'd2;
      4'b1000: key_tile = 2'd3;
      default: key_tile = 2'd0;
    endcase
  end

  always_comb begin
    exp_tile = 2'd0;
    for (int k = 0; k < MAX_TILES; k++) begin
      if (input_idx == 6'(k)) begin
        exp_tile = seq_r[2*k +: 2];
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ARM;
      end
      ARM: begin
        if (len_r == 6'd0) state_nxt = PASS;
        else if (all_up)   state_nxt = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        // a press in the same cycle as the last tick takes priority
        if (press) begin
          if (one_down && key_tile == exp_tile) state_nxt = WAIT_RELEASE;
          else                                  state_nxt = FAIL;
        end else if (tick && tcnt_last) begin
          state_nxt = FAIL;
        end
      end
      WAIT_RELEASE: begin
        if (all_up) state_nxt = idx_last ? PASS : WAIT_PRESS;
      end
      PASS:    state_nxt = IDLE;
      FAIL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    round_pass = (state == PASS);
    round_fail = (state == FAIL);
    do_start   = (state == IDLE) && start;
    do_load    = (state == WAIT_PRESS) && press && one_down;
    do_hit     = do_load && (key_tile == exp_tile);
    do_tick    = (state == WAIT_PRESS) && !press && tick;
    do_timeout = do_tick && tcnt_last;
    do_advance = (state == WAIT_RELEASE) && all_up;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      seq_r        <= '0;
      len_r        <= '0;
      input_idx    <= '0;
      tcnt         <= '0;
      tile_pressed <= '0;
      press_valid  <= 1'b0;
      fail_timeout <= 1'b0;
    end else begin
      press_valid <= do_hit;
      if (do_start) begin
        seq_r        <= seq;
        len_r        <= len_clamp;
        input_idx    <= '0;
        tcnt         <= '0;
        fail_timeout <= 1'b0;
      end
      if (do_load) begin
        tile_pressed <= key_tile;
      end
      if (do_tick && tcnt != TMAX) begin
        tcnt <= tcnt + TW'(1);
      end
      if (do_timeout) begin
        fail_timeout <= 1'b1;
      end
      if (do_advance) begin
        input_idx <= input_idx + 6'd1;
        tcnt      <= '0;
      end
    end
  end

`ifdef SCORE_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      score <= '0;
    end else if (state == PASS && score != 8'hFF) begin
      score <= score + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// tb_sequence_checker: directed and random rounds against a behavioural
// model of the key-entry game, compared every cycle.
module tb_sequence_checker;

  localparam int MT = 9;
  localparam int DB = 4;
  localparam int TO = 5;

  localparam int OFF    = 0;
  localparam int SETTLE = 1;
  localparam int EXPECT = 2;
  localparam int LIFT   = 3;
  localparam int WON    = 4;
  localparam int LOST   = 5;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        tick = 1'b0;
  logic [17:0] seq = '0;
  logic [5:0]  seq_len = '0;
  logic [3:0]  key_n = 4'hF;
  logic        busy;
  logic        press_valid;
  logic [1:0]  tile_pressed;
  logic [5:0]  input_idx;
  logic        round_pass;
  logic        round_fail;
  logic        fail_timeout;
`ifdef SCORE_EN
  logic [7:0]  score;
`endif

  sequence_checker #(
    .MAX_TILES(MT),
    .DEBOUNCE_CYCLES(DB),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .start(start),
    .seq(seq),
    .seq_len(seq_len),
    .tick(tick),
    .key_n(key_n),
    .busy(busy),
    .press_valid(press_valid),
    .tile_pressed(tile_pressed),
    .input_idx(input_idx),
    .round_pass(round_pass),
    .round_fail(round_fail),
    .fail_timeout(fail_timeout)
`ifdef SCORE_EN
    ,
    .score(score)
`endif
  );

  always #10 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_pv = 0;
  int n_pass = 0;
  int n_fail = 0;

  // behavioural model
  int          ph = OFF;
  logic [17:0] msq = '0;
  int          m_len = 0;
  int          m_idx = 0;
  int          m_ticks = 0;
  int          m_score = 0;
  logic        m_pv = 1'b0;
  logic        m_ft = 1'b0;
  logic [1:0]  m_tile = '0;
  logic [3:0]  r1 = '0;
  logic [3:0]  r2 = '0;
  logic [3:0]  m_deb = '0;
  logic [3:0]  m_prev = '0;
  logic [3:0]  hist [DB-1];

  function automatic logic [1:0] tile_of(input logic [17:0] s, input int i);
    logic [17:0] t;
    t = s >> (2 * i);
    return t[1:0];
  endfunction

  function automatic logic [1:0] sole(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) if (v[k]) r = 2'(k);
    return r;
  endfunction

  // a key's accepted level flips after DB consecutive samples that disagree
  function automatic logic [3:0] flips(input logic [3:0] s2, input logic [3:0] d);
    logic [3:0] f;
    f = 4'hF;
    for (int k = 0; k < 4; k++) begin
      if (s2[k] == d[k]) f[k] = 1'b0;
      for (int j = 0; j < DB - 1; j++) if (hist[j][k] == d[k]) f[k] = 1'b0;
    end
    return f;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ph      <= OFF;
      msq     <= '0;
      m_len   <= 0;
      m_idx   <= 0;
      m_ticks <= 0;
      m_score <= 0;
      m_pv    <= 1'b0;
      m_ft    <= 1'b0;
      m_tile  <= '0;
      r1      <= '0;
      r2      <= '0;
      m_deb   <= '0;
      m_prev  <= '0;
      for (int j = 0; j < DB - 1; j++) hist[j] <= '0;
    end else begin
      r1 <= ~key_n;
      r2 <= r1;
      hist[0] <= r2;
      for (int j = 1; j < DB - 1; j++) hist[j] <= hist[j-1];
      m_deb  <= m_deb ^ flips(r2, m_deb);
      m_prev <= m_deb;
      m_pv   <= 1'b0;
      case (ph)
        OFF: if (start) begin
          msq     <= seq;
          m_len   <= (int'(seq_len) > MT) ? MT : int'(seq_len);
          m_idx   <= 0;
          m_ticks <= 0;
          m_ft    <= 1'b0;
          ph      <= SETTLE;
        end
        SETTLE: begin
          if (m_len == 0) ph <= WON;
          else if (m_deb == 4'b0) ph <= EXPECT;
        end
        EXPECT: begin
          if ((m_deb & ~m_prev) != 4'b0) begin
            if ($countones(m_deb) == 1) begin
              m_tile <= sole(m_deb);
              if (sole(m_deb) == tile_of(msq, m_idx)) begin
                m_pv <= 1'b1;
                ph   <= LIFT;
              end else begin
                ph <= LOST;
              end
            end else begin
              ph <= LOST;
            end
          end else if (tick) begin
            if (m_ticks + 1 == TO) begin
              m_ft <= 1'b1;
              ph   <= LOST;
            end
            m_ticks <= m_ticks + 1;
          end
        end
        LIFT: if (m_deb == 4'b0) begin
          m_idx   <= m_idx + 1;
          m_ticks <= 0;
          ph      <= (m_idx + 1 == m_len) ? WON : EXPECT;
        end
        WON: begin
          ph <= OFF;
          if (m_score < 255) m_score <= m_score + 1;
        end
        default: ph <= OFF;
      endcase
    end
  end

  always @(negedge clock) begin
    n_pv   <= n_pv + int'(press_valid);
    n_pass <= n_pass + int'(round_pass);
    n_fail <= n_fail + int'(round_fail);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    chk("busy", int'(busy), int'(ph != OFF));
    chk("press_valid", int'(press_valid), int'(m_pv));
    chk("tile_pressed", int'(tile_pressed), int'(m_tile));
    chk("input_idx", int'(input_idx), m_idx);
    chk("round_pass", int'(round_pass), int'(ph == WON));
    chk("round_fail", int'(round_fail), int'(ph == LOST));
    chk("fail_timeout", int'(fail_timeout), int'(m_ft));
`ifdef SCORE_EN
    chk("score", int'(score), m_score);
`endif
  endtask

  task automatic cyc();
    @(negedge clock);
    cmp_all();
    @(posedge clock);
    #2;
    start = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic begin_round(input logic [17:0] s, input int l);
    seq     = s;
    seq_len = 6'(l);
    start   = 1'b1;
    cyc();
    repeat (3) cyc();
  endtask

  task automatic press_key(input int k);
    key_n = ~(4'b0001 << k);
    repeat (10) cyc();
    key_n = 4'hF;
    repeat (10) cyc();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      repeat (2) cyc();
    end
  endtask

  task automatic random_round();
    int guard;
    int hold;
    int gap;
    int k;
    guard = 0;
    hold  = 0;
    gap   = 3;
    begin_round(18'($urandom), $urandom_range(0, 11));
    while (ph != OFF && guard < 800) begin
      tick = ($urandom_range(0, 9) == 0);
      if (hold > 0) begin
        hold--;
        if (hold == 0) key_n = 4'hF;
      end else if (gap > 0) begin
        gap--;
      end else begin
        k = (m_idx < MT) ? int'(tile_of(msq, m_idx)) : 0;
        if ($urandom_range(0, 4) == 0) k = $urandom_range(0, 3);
        key_n = ~(4'b0001 << k);
        if ($urandom_range(0, 11) == 0) key_n[$urandom_range(0, 3)] = 1'b0;
        hold = $urandom_range(2, 12);
        gap  = $urandom_range(1, 10);
      end
      cyc();
      guard++;
    end
    chk("round_done", int'(ph == OFF), 1);
    key_n = 4'hF;
    repeat (12) cyc();
  endtask

  initial begin
    int b_pv;
    int b_pass;
    int b_fail;
    bit found;
    logic [17:0] s;

    resetn = 1'b0;
    repeat (3) cyc();
    chk("reset_busy", int'(busy), 0);
    chk("reset_idx", int'(input_idx), 0);
    chk("reset_tile", int'(tile_pressed), 0);
    chk("reset_fail_timeout", int'(fail_timeout), 0);
    resetn = 1'b1;
    repeat (3) cyc();

    // four correct presses
    b_pv = n_pv; b_pass = n_pass; b_fail = n_fail;
    begin_round(18'h000E4, 4);
    for (int i = 0; i < 4; i++) press_key(i);
    repeat (4) cyc();
    chk("t1_pv_count", n_pv - b_pv, 4);
    chk("t1_pass_count", n_pass - b_pass, 1);
    chk("t1_fail_count", n_fail - b_fail, 0);
    chk("t1_idx", int'(input_idx), 4);
    chk("t1_busy", int'(busy), 0);

    // wrong second press
    b_pv = n_pv; b_fail = n_fail;
    begin_round(18'h000E4, 4);
    press_key(0);
    press_key(2);
    chk("t2_pv_count", n_pv - b_pv, 1);
    chk("t2_tile", int'(tile_pressed), 2);
    chk("t2_fail_count", n_fail - b_fail, 1);
    chk("t2_fail_timeout", int'(fail_timeout), 0);
    chk("t2_idx", int'(input_idx), 1);

    // timeout on the fifth tick
    b_fail = n_fail;
    begin_round(18'h000E4, 3);
    ticks(4);
    chk("t3_no_fail_4", n_fail - b_fail, 0);
    ticks(1);
    chk("t3_fail_5", n_fail - b_fail, 1);
    chk("t3_fail_timeout", int'(fail_timeout), 1);

    // final tick coincides with a correct press
    b_pv = n_pv; b_fail = n_fail; b_pass = n_pass;
    begin_round(18'h000E4, 3);
    ticks(4);
    found = 1'b0;
    key_n = 4'b1110;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ph == EXPECT && (m_deb & ~m_prev) != 4'b0) begin
        tick  = 1'b1;
        found = 1'b1;
      end
      cyc();
    end
    repeat (8) cyc();
    key_n = 4'hF;
    repeat (10) cyc();
    chk("t3_coincide_found", int'(found), 1);
    chk("t3_coincide_no_fail", n_fail - b_fail, 0);
    chk("t3_coincide_pv", n_pv - b_pv, 1);
    press_key(1);
    press_key(2);
    chk("t3_coincide_pass", n_pass - b_pass, 1);

    // bouncing key gives one press
    b_pv = n_pv;
    begin_round(18'h000E4, 4);
    for (int i = 0; i < 4; i++) begin
      key_n[0] = 1'b0; repeat (2) cyc();
      key_n[0] = 1'b1; repeat (2) cyc();
    end
    key_n[0] = 1'b0; repeat (10) cyc();
    key_n[0] = 1'b1; repeat (10) cyc();
    chk("t4_bounce_pv", n_pv - b_pv, 1);
    ticks(5);

    // key held across start is ignored until released
    b_pv = n_pv; b_pass = n_pass; b_fail = n_fail;
    key_n = 4'b1110;
    repeat (10) cyc();
    begin_round(18'h000E4, 4);
    repeat (10) cyc();
    chk("t4_held_no_pv", n_pv - b_pv, 0);
    chk("t4_held_busy", int'(busy), 1);
    key_n = 4'hF;
    repeat (10) cyc();
    press_key(0);
    chk("t4_after_release_pv", n_pv - b_pv, 1);

    // reset mid-round
    resetn = 1'b0;
    #5;
    chk("rst_busy", int'(busy), 0);
    chk("rst_pv", int'(press_valid), 0);
    chk("rst_idx", int'(input_idx), 0);
    chk("rst_tile", int'(tile_pressed), 0);
    chk("rst_pass", int'(round_pass), 0);
    chk("rst_fail", int'(round_fail), 0);
    cyc();
    resetn = 1'b1;
    repeat (3) cyc();
    chk("rst_no_pulse_pass", n_pass - b_pass, 0);
    chk("rst_no_pulse_fail", n_fail - b_fail, 0);

    // zero-length round
    b_pv = n_pv; b_pass = n_pass;
    begin_round(18'h3FFFF, 0);
    chk("len0_pass", n_pass - b_pass, 1);
    chk("len0_no_pv", n_pv - b_pv, 0);

    // length clamped to MAX_TILES
    b_pass = n_pass;
    s = 18'($urandom);
    begin_round(s, 12);
    for (int i = 0; i < MT; i++) press_key(int'(tile_of(s, i)));
    repeat (4) cyc();
    chk("len12_pass", n_pass - b_pass, 1);
    chk("len12_idx", int'(input_idx), 9);

    // start while busy has no effect
    b_pass = n_pass;
    begin_round(18'h0000B, 2);
    press_key(3);
    seq = '0;
    seq_len = 6'd1;
    start = 1'b1;
    cyc();
    press_key(2);
    repeat (4) cyc();
    chk("busy_start_pass", n_pass - b_pass, 1);
    chk("busy_start_idx", int'(input_idx), 2);

    for (int r = 0; r < 40; r++) random_round();

`ifdef SCORE_EN
    resetn = 1'b0;
    cyc();
    resetn = 1'b1;
    repeat (2) cyc();
    for (int r = 0; r < 3; r++) begin_round(18'h0, 0);
    begin_round(18'h0, 2);
    ticks(5);
    repeat (3) cyc();
    chk("score_3", int'(score), 3);
    for (int r = 0; r < 256; r++) begin_round(18'h0, 0);
    chk("score_sat", int'(score), 255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
